// File: rtl/cvs_pkg.sv
// Shared definitions for the capacitor-voltage rank sorter: IEEE-754 field
// positions, sorter state encoding and the pairwise-compare count.
package cvs_pkg;

   localparam int unsigned EXP_MSB = 30;
   localparam int unsigned EXP_LSB = 23;
   localparam int unsigned MAN_MSB = 22;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      SELECT
   } state_t;

   // Number of distinct unordered pairs among n submodules.
   function automatic int unsigned pair_count(input int unsigned n);
      return (n * (n - 1)) / 2;
   endfunction

endpackage

// File: rtl/cvs_fp_mag_cmp.sv
// Combinational magnitude compare of two IEEE-754 single words.
// The sign bit is ignored; gt is high only when |a| is strictly larger than |b|.
module cvs_fp_mag_cmp
   import cvs_pkg::*;
#(
   parameter int unsigned VW = 32
) (
   input  logic [VW-1:0] a,
   input  logic [VW-1:0] b,
   output logic          gt
);

   logic [EXP_MSB-EXP_LSB:0] exp_a;
   logic [EXP_MSB-EXP_LSB:0] exp_b;
   logic [MAN_MSB:0]         man_a;
   logic [MAN_MSB:0]         man_b;
   logic                     unused_sign;

   // Exponent decides first; mantissa only breaks an exponent tie.
   always_comb begin
      exp_a       = a[EXP_MSB:EXP_LSB];
      exp_b       = b[EXP_MSB:EXP_LSB];
      man_a       = a[MAN_MSB:0];
      man_b       = b[MAN_MSB:0];
      gt          = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a > man_b));
      unused_sign = ^{a[VW-1:EXP_MSB+1], b[VW-1:EXP_MSB+1]};
   end

endmodule

// File: rtl/cvs_rank_sorter.sv
// Snapshot N_SM capacitor voltages, rank them by one pairwise compare per
// clock, then derive the arm insertion mask from the ranks and arm current sign.
module cvs_rank_sorter
   import cvs_pkg::*;
#(
   parameter int unsigned N_SM = 8,
   parameter int unsigned VW   = 32,
   parameter int unsigned RW   = $clog2(N_SM)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N_SM*VW-1:0]   v_flat,
   input  logic [RW:0]          n_ins,
   input  logic                 i_arm_pos,
   output logic                 busy,
   output logic                 done,
   output logic [N_SM*RW-1:0]   rank_flat,
   output logic [N_SM-1:0]      ins_mask
);

   localparam logic [RW-1:0] LAST_J = RW'(N_SM - 1);
   localparam logic [RW-1:0] LAST_I = RW'(N_SM - 2);
   localparam logic [RW:0]   N_CNT  = (RW+1)'(N_SM);

   state_t          state;
   logic [VW-1:0]   snap [N_SM];
   logic [RW:0]     acc  [N_SM];
   logic [RW:0]     n_sel;
   logic            pos_sel;
   logic [RW-1:0]   pi;
   logic [RW-1:0]   pj;
   logic            gt;
   logic [N_SM*RW-1:0] rank_next;
   logic [N_SM-1:0]    mask_next;

   cvs_fp_mag_cmp #(.VW(VW)) u_cmp (
      .a  (snap[pi]),
      .b  (snap[pj]),
      .gt (gt)
   );

   // Ranks are the final accumulator values; the mask picks the lowest n
   // (charging) or highest n (discharging) ranks.
   always_comb begin
      rank_next = '0;
      mask_next = '0;
      for (int unsigned k = 0; k < N_SM; k++) begin
         rank_next[k*RW +: RW] = acc[k][RW-1:0];
         mask_next[k] = pos_sel ? (acc[k] < n_sel) : (acc[k] >= (N_CNT - n_sel));
      end
   end

   // Sort sequencer: capture, walk all pairs in order, then register results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rank_flat <= '0;
         ins_mask  <= '0;
         n_sel     <= '0;
         pos_sel   <= 1'b0;
         pi        <= '0;
         pj        <= '0;
         for (int unsigned k = 0; k < N_SM; k++) begin
            snap[k] <= '0;
            acc[k]  <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int unsigned k = 0; k < N_SM; k++) begin
                     snap[k] <= v_flat[k*VW +: VW];
                     acc[k]  <= '0;
                  end
                  n_sel   <= (n_ins > N_CNT) ? N_CNT : n_ins;
                  pos_sel <= i_arm_pos;
                  pi      <= '0;
                  pj      <= RW'(1);
                  busy    <= 1'b1;
                  state   <= COMPARE;
               end
            end
            COMPARE: begin
               // Ties credit the higher index so ranks stay a permutation.
               if (gt) acc[pi] <= acc[pi] + (RW+1)'(1);
               else    acc[pj] <= acc[pj] + (RW+1)'(1);
               if (pj == LAST_J) begin
                  if (pi == LAST_I) begin
                     state <= SELECT;
                  end else begin
                     pi <= pi + RW'(1);
                     pj <= pi + RW'(2);
                  end
               end else begin
                  pj <= pj + RW'(1);
               end
            end
            SELECT: begin
               rank_flat <= rank_next;
               ins_mask  <= mask_next;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
